// File: rtl/spi_master_tx.sv
`timescale 1ns/1ps
// TX shift stage of the SPI master: takes 32-bit words over valid/ready, shifts them out
// MSB-first on the clock generator's falling-edge strobe. Define SPI_MASTER_TX_QUAD_EN for quad mode.
module spi_master_tx #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             tx_edge,
   input  logic [CNT_W-1:0] counter_in,
   input  logic             counter_upd,
   input  logic [31:0]      data,
   input  logic             data_valid,
`ifdef SPI_MASTER_TX_QUAD_EN
   input  logic             quad,
`endif
   output logic             data_ready,
   output logic             clk_en,
   output logic             tx_done,
   output logic [3:0]       sdo
);

   typedef enum logic [1:0] {IDLE, TRANSMIT, WAIT, DONE} state_t;

   state_t           state;
   logic [31:0]      shift;
   logic [31:0]      shifted;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] bitcnt;
   logic [4:0]       wordcnt;
   logic             quad_r;
   logic [2:0]       step;
   logic [5:0]       word_len;
   logic [CNT_W:0]   bit_next;
   logic [5:0]       word_next;
   logic             last_bit;
   logic             word_end;

`ifdef SPI_MASTER_TX_QUAD_EN
   assign sdo     = quad_r ? shift[31:28] : {3'b000, shift[31]};
   assign shifted = quad_r ? {shift[27:0], 4'b0000} : {shift[30:0], 1'b0};
`else
   assign quad_r  = 1'b0;
   assign sdo     = {3'b000, shift[31]};
   assign shifted = {shift[30:0], 1'b0};
`endif

   assign step      = quad_r ? 3'd4 : 3'd1;
   assign word_len  = quad_r ? 6'd8 : 6'd32;
   // One extra bit so a quad step past a non-multiple-of-4 target cannot wrap.
   assign bit_next  = {1'b0, bitcnt} + (CNT_W+1)'(step);
   assign last_bit  = bit_next >= {1'b0, target};
   assign word_next = {1'b0, wordcnt} + 6'd1;
   assign word_end  = word_next == word_len;

   always_comb begin
      data_ready = 1'b0;
      case (state)
         IDLE:     data_ready = en && data_valid && (target != '0);
         TRANSMIT: data_ready = tx_edge && !last_bit && word_end && data_valid;
         WAIT:     data_ready = data_valid;
         default:  data_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         shift   <= '0;
         target  <= '0;
         bitcnt  <= '0;
         wordcnt <= '0;
         clk_en  <= 1'b0;
         tx_done <= 1'b0;
`ifdef SPI_MASTER_TX_QUAD_EN
         quad_r  <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               clk_en <= 1'b0;
               if (counter_upd) target <= counter_in;
               if (en) begin
                  if (target == '0) begin
                     tx_done <= 1'b1;
                  end else begin
                     bitcnt  <= '0;
                     wordcnt <= '0;
`ifdef SPI_MASTER_TX_QUAD_EN
                     quad_r  <= quad;
`endif
                     if (data_valid) begin
                        shift  <= data;
                        clk_en <= 1'b1;
                        state  <= TRANSMIT;
                     end else begin
                        state  <= WAIT;
                     end
                  end
               end
            end
            TRANSMIT: begin
               if (tx_edge) begin
                  bitcnt  <= bit_next[CNT_W-1:0];
                  wordcnt <= word_next[4:0];
                  // The final edge does not shift, so sdo keeps the last bit through DONE.
                  if (last_bit) begin
                     clk_en  <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= DONE;
                  end else begin
                     shift <= shifted;
                     if (word_end) begin
                        wordcnt <= '0;
                        if (data_valid) begin
                           shift <= data;
                        end else begin
                           clk_en <= 1'b0;
                           state  <= WAIT;
                        end
                     end
                  end
               end
            end
            WAIT: begin
               if (data_valid) begin
                  shift   <= data;
                  wordcnt <= '0;
                  clk_en  <= 1'b1;
                  state   <= TRANSMIT;
               end
            end
            default: begin
               clk_en <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
